// File: rtl/pcs_lane_deskew_rx.sv
// pcs_lane_deskew_rx
//   Multi-lane RX deskew stage placed after per-lane alignment marker lock.
//   Each physical lane is buffered from the block after its first alignment
//   marker (AM). All lanes are released together, so one output word holds
//   the same-time block of every lane. Lanes are reordered from physical to
//   logical order, and AM blocks are removed from the stream.
// Ports
//   clk       clock
//   reset     asynchronous, active-high reset
//   valid_i   blocks on block_i valid this cycle (common to all lanes)
//   block_i   physical lane p at [p*BLOCK_W +: BLOCK_W]
//   lock_v_i  per-lane AM lock
//   am_v_i    per-lane "this block is an AM" (qualified by valid_i)
//   lane_i    logical lane id decoded on physical lane p
//   valid_o   block_o holds one deskewed word
//   block_o   logical lane l at [l*BLOCK_W +: BLOCK_W]
//   deskew_o  lanes deskewed, output stream live
//   err_o     one-cycle pulse on skew overflow or duplicate lane id
module pcs_lane_deskew_rx #(
  parameter  int LANE_N  = 4,
  parameter  int BLOCK_W = 66,
  parameter  int DEPTH   = 8,
  localparam int LANE_W  = $clog2(LANE_N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [LANE_N*BLOCK_W-1:0] block_i,
  input  logic [LANE_N-1:0]         lock_v_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic [LANE_N*LANE_W-1:0]  lane_i,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] block_o,
  output logic                      deskew_o,
  output logic                      err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'b001;
  localparam logic [2:0] S_WAIT    = 3'b010;
  localparam logic [2:0] S_ALIGNED = 3'b100;

  logic [2:0]               state;
  logic [2:0]               next_state;
  logic [LANE_N-1:0]        started;
  logic [LANE_N-1:0]        start_now;
  logic [BLOCK_W-1:0]       mem      [LANE_N][DEPTH];
  logic [PTR_W-1:0]         wr_ptr   [LANE_N];
  logic [PTR_W-1:0]         rd_ptr   [LANE_N];
  logic [CNT_W-1:0]         count    [LANE_N];
  logic [LANE_W-1:0]        lane_map [LANE_N];
  logic [LANE_N-1:0]        wr_due;
  logic [LANE_N-1:0]        wr_en;
  logic [LANE_N-1:0]        full;
  logic [LANE_N-1:0]        nonempty;
  logic [LANE_N-1:0]        ovf;
  logic                     all_lock;
  logic                     pop_ok;
  logic                     pop;
  logic                     all_started;
  logic                     dup_err;
  logic                     valid_nxt;
  logic                     deskew_nxt;
  logic                     err_nxt;
  logic [LANE_N*BLOCK_W-1:0] word;

  // True when the decoded ids form a permutation of 0..LANE_N-1.
  function automatic logic ids_are_perm(input logic [LANE_N*LANE_W-1:0] ids);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < LANE_N; i++) begin
      if (int'(ids[i*LANE_W +: LANE_W]) >= LANE_N) begin
        ok = 1'b0;
      end else begin
        for (int j = i + 1; j < LANE_N; j++) begin
          if (ids[i*LANE_W +: LANE_W] == ids[j*LANE_W +: LANE_W]) begin
            ok = 1'b0;
          end else begin
            ok = ok;
          end
        end
      end
    end
    return ok;
  endfunction

  // Per-lane write qualification, fill status, overflow and pop decision.
  always_comb begin
    all_lock  = &lock_v_i;
    wr_due    = '0;
    wr_en     = '0;
    full      = '0;
    nonempty  = '0;
    ovf       = '0;
    start_now = started;
    for (int p = 0; p < LANE_N; p++) begin
      full[p]     = (count[p] == FULL_CNT);
      nonempty[p] = (count[p] != '0);
      if ((state == S_WAIT) || (state == S_ALIGNED)) begin
        wr_due[p] = valid_i & started[p] & ~am_v_i[p];
      end else begin
        wr_due[p] = 1'b0;
      end
      if (state == S_WAIT) begin
        start_now[p] = started[p] | (valid_i & am_v_i[p]);
      end else begin
        start_now[p] = started[p];
      end
    end
    // A full FIFO may accept a write only when the common pop frees a slot.
    pop_ok = (state == S_ALIGNED) & (&nonempty);
    pop    = pop_ok & all_lock;
    for (int p = 0; p < LANE_N; p++) begin
      ovf[p]   = wr_due[p] & full[p] & ~pop_ok;
      wr_en[p] = wr_due[p] & (~full[p] | pop);
    end
    all_started = &start_now;
    dup_err     = (state == S_WAIT) & all_started & ~ids_are_perm(lane_i);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; lock loss outranks every other transition.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (all_lock) next_state = S_WAIT;
        else          next_state = S_IDLE;
      end
      S_WAIT: begin
        if (!all_lock)       next_state = S_IDLE;
        else if (|ovf)       next_state = S_IDLE;
        else if (dup_err)    next_state = S_IDLE;
        else if (all_started) next_state = S_ALIGNED;
        else                 next_state = S_WAIT;
      end
      S_ALIGNED: begin
        if (!all_lock)  next_state = S_IDLE;
        else if (|ovf)  next_state = S_IDLE;
        else            next_state = S_ALIGNED;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode and physical-to-logical reorder of the FIFO heads.
  always_comb begin
    valid_nxt  = pop;
    deskew_nxt = (state == S_ALIGNED) & (next_state == S_ALIGNED);
    err_nxt    = (|ovf) | dup_err;
    word       = '0;
    for (int p = 0; p < LANE_N; p++) begin
      word[int'(lane_map[p])*BLOCK_W +: BLOCK_W] = mem[p][rd_ptr[p]];
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o  <= 1'b0;
      deskew_o <= 1'b0;
      err_o    <= 1'b0;
      block_o  <= '0;
    end else begin
      valid_o  <= valid_nxt;
      deskew_o <= deskew_nxt;
      err_o    <= err_nxt;
      if (pop) block_o <= word;
    end
  end

  // FIFO pointers, occupancy, start flags and lane map; IDLE flushes all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= '0;
      for (int p = 0; p < LANE_N; p++) begin
        wr_ptr[p]   <= '0;
        rd_ptr[p]   <= '0;
        count[p]    <= '0;
        lane_map[p] <= '0;
      end
    end else if (state == S_IDLE) begin
      started <= '0;
      for (int p = 0; p < LANE_N; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      started <= start_now;
      for (int p = 0; p < LANE_N; p++) begin
        if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (pop)      rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        case ({wr_en[p], pop})
          2'b10:   count[p] <= count[p] + CNT_W'(1);
          2'b01:   count[p] <= count[p] - CNT_W'(1);
          default: count[p] <= count[p];
        endcase
        if ((state == S_WAIT) && (next_state == S_ALIGNED)) begin
          lane_map[p] <= lane_i[p*LANE_W +: LANE_W];
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int p = 0; p < LANE_N; p++) begin
      if (wr_en[p]) mem[p][wr_ptr[p]] <= block_i[p*BLOCK_W +: BLOCK_W];
    end
  end

endmodule

// File: tb/tb_pcs_lane_deskew_rx.sv
module tb_pcs_lane_deskew_rx;
  localparam int LANE_N  = 4;
  localparam int BLOCK_W = 66;
  localparam int DEPTH   = 8;
  localparam int LANE_W  = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      valid_i;
  logic [LANE_N*BLOCK_W-1:0] block_i;
  logic [LANE_N-1:0]         lock_v_i;
  logic [LANE_N-1:0]         am_v_i;
  logic [LANE_N*LANE_W-1:0]  lane_i;
  logic                      valid_o;
  logic [LANE_N*BLOCK_W-1:0] block_o;
  logic                      deskew_o;
  logic                      err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcs_lane_deskew_rx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .block_i(block_i),
    .lock_v_i(lock_v_i), .am_v_i(am_v_i), .lane_i(lane_i),
    .valid_o(valid_o), .block_o(block_o), .deskew_o(deskew_o), .err_o(err_o)
  );

  typedef struct {
    logic [3:0] lock;
    logic       vld;
    logic [3:0] am;
    logic [7:0] n;
    logic       ev;
    logic       ed;
    logic       ee;
    logic [7:0] en;
  } vec_t;

  vec_t tbl [13];

  // Payload block n of physical lane p.
  function automatic logic [BLOCK_W-1:0] mk(input int p, input int n);
    logic [7:0] pb;
    logic [7:0] nb;
    pb = 8'(p);
    nb = 8'(n);
    return {2'b01, 48'hA5A5_5A5A_0000, pb, nb};
  endfunction

  function automatic logic [BLOCK_W-1:0] am_blk(input int p);
    logic [7:0] pb;
    pb = 8'(p);
    return {2'b10, 56'h4D_4D4D_4D4D_4D4D, pb};
  endfunction

  task automatic drive(input logic [3:0] lock, input logic vld, input logic [3:0] am,
                       input logic [31:0] nv);
    lock_v_i = lock;
    valid_i  = vld;
    am_v_i   = am;
    for (int p = 0; p < LANE_N; p++) begin
      block_i[p*BLOCK_W +: BLOCK_W] = am[p] ? am_blk(p) : mk(p, int'(nv[p*8 +: 8]));
    end
  endtask

  // Lane p sends junk before its AM at cycle s_p, then payload k - s_p.
  task automatic drive_skew(input int k, input int s0, input int s1, input int s2, input int s3);
    int s [4];
    logic [3:0]  am;
    logic [31:0] nv;
    s = '{s0, s1, s2, s3};
    am = 4'h0;
    nv = 32'h0;
    for (int p = 0; p < LANE_N; p++) begin
      am[p] = (k == s[p]);
      nv[p*8 +: 8] = (k > s[p]) ? 8'(k - s[p]) : 8'hEE;
    end
    drive(4'hF, 1'b1, am, nv);
  endtask

  function automatic logic [31:0] rep(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {4{b}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [BLOCK_W-1:0] act,
                         input logic [BLOCK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic ed, input logic ee);
    chk_bit({nm, "_valid"}, valid_o, ev);
    chk_bit({nm, "_deskew"}, deskew_o, ed);
    chk_bit({nm, "_err"}, err_o, ee);
  endtask

  // src holds, for each logical lane, the physical lane feeding it.
  task automatic chk_word(input string nm, input int n, input logic [7:0] src);
    for (int l = 0; l < LANE_N; l++) begin
      chk_blk(nm, block_o[l*BLOCK_W +: BLOCK_W], mk(int'(src[l*2 +: 2]), n));
    end
  endtask

  // Force IDLE with a lock drop, then enter WAIT_AM.
  task automatic prelude;
    drive(4'h7, 1'b0, 4'h0, 32'h0);
    tick;
    chk_bit("pre_valid", valid_o, 1'b0);
    chk_bit("pre_deskew", deskew_o, 1'b0);
    drive(4'hF, 1'b0, 4'h0, 32'h0);
    tick;
  endtask

  task automatic run_tbl(input string nm, input logic [7:0] cfg, input logic [7:0] src);
    lane_i = cfg;
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].lock, tbl[r].vld, tbl[r].am, rep(int'(tbl[r].n)));
      tick;
      chk_out(nm, tbl[r].ev, tbl[r].ed, tbl[r].ee);
      if (tbl[r].ev) chk_word({nm, "_word"}, int'(tbl[r].en), src);
    end
  endtask

  initial begin
    //          lock   vld   am    n      ev    ed    ee    en
    tbl[0]  = '{4'hB, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{4'hF, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'hF, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'h0, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{4'hF, 1'b1, 4'h0, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{4'hF, 1'b1, 4'h0, 8'd3, 1'b1, 1'b1, 1'b0, 8'd2};
    tbl[6]  = '{4'hF, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[7]  = '{4'hF, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{4'hF, 1'b1, 4'hF, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{4'hF, 1'b1, 4'h0, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{4'hF, 1'b1, 4'h0, 8'd5, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[11] = '{4'hF, 1'b0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd5};
    tbl[12] = '{4'hF, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0};

    reset = 1'b1;
    lane_i = 8'hE4;
    drive(4'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk_bit("reset_blk", |block_o, 1'b0);
    tick;
    tick;
    reset = 1'b0;

    // Zero skew, identity, then permuted ids {2,0,3,1}.
    run_tbl("ident", 8'hE4, 8'hE4);
    run_tbl("perm", 8'h72, 8'h8D);

    // Skew 0/1/3/5: lane 3's AM at k=5, first pop at k=7.
    lane_i = 8'hE4;
    prelude();
    for (int k = 0; k < 20; k++) begin
      drive_skew(k, 0, 1, 3, 5);
      tick;
      chk_out("skew", k >= 7, k >= 6, 1'b0);
      if (k >= 7) chk_word("skew_word", k - 6, 8'hE4);
    end

    // Skew 8 on lane 0: overflow on the first ALIGNED cycle (k=9).
    prelude();
    for (int k = 0; k < 16; k++) begin
      drive_skew(k, 0, 8, 8, 8);
      tick;
      chk_out("ovf", 1'b0, 1'b0, k == 9);
    end

    // Duplicate ids {0,0,1,2}.
    lane_i = 8'h90;
    prelude();
    for (int k = 0; k < 6; k++) begin
      drive_skew(k, 0, 0, 0, 0);
      tick;
      chk_out("dup", 1'b0, 1'b0, k == 0);
    end

    // Lock loss in ALIGNED, valid 1,0,1 without AMs, then a fresh AM.
    lane_i = 8'hE4;
    prelude();
    drive(4'hF, 1'b1, 4'hF, 32'h0);
    tick;
    chk_out("ll_am", 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      drive(4'hF, 1'b1, 4'h0, rep(n));
      tick;
      chk_out("ll_run", n >= 2, 1'b1, 1'b0);
      if (n >= 2) chk_word("ll_word", n - 1, 8'hE4);
    end
    drive(4'hB, 1'b1, 4'h0, rep(5));
    tick;
    chk_out("ll_drop", 1'b0, 1'b0, 1'b0);
    drive(4'hF, 1'b1, 4'h0, rep(6));
    tick;
    chk_out("ll_v1", 1'b0, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 4'h0, 32'h0);
    tick;
    chk_out("ll_v0", 1'b0, 1'b0, 1'b0);
    drive(4'hF, 1'b1, 4'h0, rep(7));
    tick;
    chk_out("ll_v1b", 1'b0, 1'b0, 1'b0);
    drive(4'hF, 1'b1, 4'hF, 32'h0);
    tick;
    chk_out("ll_ream", 1'b0, 1'b0, 1'b0);
    drive(4'hF, 1'b1, 4'h0, rep(8));
    tick;
    chk_out("ll_w8", 1'b0, 1'b1, 1'b0);
    drive(4'hF, 1'b1, 4'h0, rep(9));
    tick;
    chk_out("ll_w9", 1'b1, 1'b1, 1'b0);
    chk_word("ll_resync", 8, 8'hE4);

    // Reset mid-stream drops outputs without a clock edge.
    drive(4'hF, 1'b1, 4'h0, rep(10));
    #3;
    reset = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 1'b0);
    chk_bit("midrst_blk", |block_o, 1'b0);
    tick;
    reset = 1'b0;

    // After reset, partial lock keeps the block in IDLE.
    drive(4'hE, 1'b1, 4'hF, 32'h0);
    tick;
    chk_out("partlock_am", 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      drive(4'hE, 1'b1, 4'h0, rep(n));
      tick;
      chk_out("partlock", 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
